// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the register file write port: buffers accepted
// register writes, drains one per cycle, and forwards pending values to decode.
module regfile_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_W-1:0]            in_reg,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            wr_reg,
    output logic [DATA_W-1:0]            wr_data,
    input  logic [ADDR_W-1:0]            rd_reg1,
    input  logic [ADDR_W-1:0]            rd_reg2,
    output logic                         fwd_hit1,
    output logic [DATA_W-1:0]            fwd_data1,
    output logic                         fwd_hit2,
    output logic [DATA_W-1:0]            fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [ADDR_W-1:0] ZERO_REG = '1;

    logic [ADDR_W-1:0] q_reg  [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [DEPTH-1:0]  q_vld;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              push;
    logic              pop;

    // Writes to the zero register complete the handshake but are dropped.
    assign in_ready = (count != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready && (in_reg != ZERO_REG);
    assign pop      = (count != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            q_vld   <= '0;
            wr_en   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else begin
            if (pop) begin
                wr_en       <= 1'b1;
                wr_reg      <= q_reg[head];
                wr_data     <= q_data[head];
                q_vld[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end else begin
                wr_en <= 1'b0;
            end
            if (push) begin
                q_vld[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entry storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            q_reg[tail]  <= in_reg;
            q_data[tail] <= in_data;
        end
    end

    // Bypass: scan oldest to newest so the newest matching write wins,
    // starting from the output stage which is older than any FIFO entry.
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [ADDR_W-1:0] rd;
        logic              hit;
        logic [DATA_W-1:0] data;
        logic [PTR_W-1:0]  idx;

        assign rd = (p == 0) ? rd_reg1 : rd_reg2;

        always_comb begin
            hit  = 1'b0;
            data = '0;
            idx  = '0;
            if (rd != ZERO_REG) begin
                if (wr_en && (wr_reg == rd)) begin
                    hit  = 1'b1;
                    data = wr_data;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    idx = head + PTR_W'(i);
                    if (q_vld[idx] && (q_reg[idx] == rd)) begin
                        hit  = 1'b1;
                        data = q_data[idx];
                    end
                end
            end
        end
    end

    assign fwd_hit1  = g_port[0].hit;
    assign fwd_data1 = g_port[0].data;
    assign fwd_hit2  = g_port[1].hit;
    assign fwd_data2 = g_port[1].data;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_regfile_wb_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] in_reg = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_reg1 = '0;
    logic [ADDR_W-1:0] rd_reg2 = '0;
    logic              fwd_hit1;
    logic [DATA_W-1:0] fwd_data1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data2;
    logic [CNT_W-1:0]  count;

    regfile_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
        .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
        .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
        .count(count)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: pending writes as a queue plus the output stage.
    typedef struct packed {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              q[$];
    ent_t              m_e;
    bit                m_acc;
    logic              m_wr_en = 1'b0;
    logic [ADDR_W-1:0] m_wr_reg = '0;
    logic [DATA_W-1:0] m_wr_data = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_wr_en   = 1'b0;
            m_wr_reg  = '0;
            m_wr_data = '0;
        end else begin
            m_acc = in_valid && (q.size() < DEPTH);
            if (q.size() > 0) begin
                m_e       = q.pop_front();
                m_wr_en   = 1'b1;
                m_wr_reg  = m_e.r;
                m_wr_data = m_e.d;
            end else begin
                m_wr_en = 1'b0;
            end
            if (m_acc && in_reg != 5'd31) begin
                m_e.r = in_reg;
                m_e.d = in_data;
                q.push_back(m_e);
            end
        end
    end

    function automatic void model_fwd(input logic [ADDR_W-1:0] rd, output logic hit,
                                      output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (rd == 5'd31) return;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].r == rd) begin
                hit = 1'b1;
                d   = q[i].d;
                return;
            end
        end
        if (m_wr_en && m_wr_reg == rd) begin
            hit = 1'b1;
            d   = m_wr_data;
        end
    endfunction

    logic              e_hit1, e_hit2;
    logic [DATA_W-1:0] e_dat1, e_dat2;

    always @(negedge clk) begin
        if (chk_en) begin
            model_fwd(rd_reg1, e_hit1, e_dat1);
            model_fwd(rd_reg2, e_hit2, e_dat2);
            check("wr_en",     64'(wr_en),     64'(m_wr_en));
            check("wr_reg",    64'(wr_reg),    64'(m_wr_reg));
            check("wr_data",   wr_data,        m_wr_data);
            check("count",     64'(count),     64'(q.size()));
            check("in_ready",  64'(in_ready),  64'(q.size() != DEPTH));
            check("fwd_hit1",  64'(fwd_hit1),  64'(e_hit1));
            check("fwd_data1", fwd_data1,      e_dat1);
            check("fwd_hit2",  64'(fwd_hit2),  64'(e_hit2));
            check("fwd_data2", fwd_data2,      e_dat2);
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        in_valid = v;
        in_reg   = r;
        in_data  = d;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_wr_en",    64'(wr_en),    64'h0);
        check("rst_wr_reg",   64'(wr_reg),   64'h0);
        check("rst_wr_data",  wr_data,       64'h0);
        check("rst_count",    64'(count),    64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);
        check("rst_fwd_hit1", 64'(fwd_hit1), 64'h0);
        check("rst_fwd_hit2", 64'(fwd_hit2), 64'h0);
        edge1();
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Single write, reg 3
        drive(1'b1, 5'd3, 64'hDEAD_BEEF);
        edge1();
        check("t2_count", 64'(count), 64'h1);
        drive(1'b0, '0, '0);
        edge1();
        check("t2_wr_en",   64'(wr_en),  64'h1);
        check("t2_wr_reg",  64'(wr_reg), 64'h3);
        check("t2_wr_data", wr_data,     64'hDEAD_BEEF);
        edge1();
        check("t2_wr_en_off", 64'(wr_en), 64'h0);

        // Five back-to-back writes drain in order
        drive(1'b1, 5'd1, 64'h10);
        for (int k = 1; k <= 5; k++) begin
            edge1();
            if (k >= 2) check("t3_wr_reg", 64'(wr_reg), 64'(k - 1));
            if (k < 5) drive(1'b1, 5'(k + 1), 64'((k + 1) * 16));
            else       drive(1'b0, '0, '0);
        end
        edge1();
        check("t3_wr_reg_last",  64'(wr_reg),  64'h5);
        check("t3_wr_data_last", wr_data,      64'h50);
        edge1();
        check("t3_wr_en_off", 64'(wr_en), 64'h0);

        // Two writes to reg 7: newest value forwarded
        rd_reg1 = 5'd7;
        drive(1'b1, 5'd7, 64'h1);
        edge1();
        check("t4_hit_a",  64'(fwd_hit1), 64'h1);
        check("t4_data_a", fwd_data1,     64'h1);
        drive(1'b1, 5'd7, 64'h2);
        edge1();
        check("t4_hit_b",  64'(fwd_hit1), 64'h1);
        check("t4_data_b", fwd_data1,     64'h2);
        drive(1'b0, '0, '0);
        edge1();
        check("t4_data_c", fwd_data1, 64'h2);
        edge1();
        check("t4_hit_d",  64'(fwd_hit1), 64'h0);
        check("t4_data_d", fwd_data1,     64'h0);

        // Write to X31 is accepted and dropped
        rd_reg2 = 5'd31;
        drive(1'b1, 5'd31, 64'hFFFF);
        #1;
        check("t5_in_ready", 64'(in_ready), 64'h1);
        edge1();
        check("t5_count", 64'(count),    64'h0);
        check("t5_hit2",  64'(fwd_hit2), 64'h0);
        drive(1'b0, '0, '0);
        edge1();
        check("t5_wr_en", 64'(wr_en), 64'h0);

        // Asynchronous reset mid-operation
        drive(1'b1, 5'd10, 64'hA);
        edge1();
        drive(1'b1, 5'd11, 64'hB);
        edge1();
        drive(1'b1, 5'd12, 64'hC);
        edge1();
        drive(1'b0, '0, '0);
        check("t6_pre_wr_en", 64'(wr_en), 64'h1);
        #1 reset_n = 1'b0;
        #1;
        check("t6_wr_en",   64'(wr_en),  64'h0);
        check("t6_wr_reg",  64'(wr_reg), 64'h0);
        check("t6_wr_data", wr_data,     64'h0);
        check("t6_count",   64'(count),  64'h0);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            edge1();
            check("t6_post_wr_en", 64'(wr_en), 64'h0);
            check("t6_post_count", 64'(count), 64'h0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            edge1();
            in_valid = 1'($urandom_range(0, 1));
            in_reg   = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            in_data  = {$urandom, $urandom};
            rd_reg1  = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            rd_reg2  = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end
        drive(1'b0, '0, '0);
        edge1();
        edge1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
